// File: rtl/ppu_cpu_port.sv
// ppu_cpu_port: CPU-facing register responder of the PPU ($2000-$3FFF).
// Ports: CPU bus (clk_ph2, rst, Addr_bus, Data_bus_in/out, R_nW, data_oe, nmi),
//   render state (ctrl, mask, v_addr, t_addr, fine_x), status inputs
//   (vblank_set/clr, spr0_hit, spr_ovf), OAM port, VRAM req/ack port, drop.
module ppu_cpu_port #(
    parameter logic [2:0] DEC_HI  = 3'b001,
    parameter int         VRAM_AW = 14
) (
    input  logic               clk_ph2,
    input  logic               rst,
    input  logic [15:0]        Addr_bus,
    input  logic [7:0]         Data_bus_in,
    input  logic               R_nW,
    output logic [7:0]         Data_bus_out,
    output logic               data_oe,
    output logic               nmi,
    output logic [7:0]         ctrl,
    output logic [7:0]         mask,
    output logic [14:0]        v_addr,
    output logic [14:0]        t_addr,
    output logic [2:0]         fine_x,
    input  logic               vblank_set,
    input  logic               vblank_clr,
    input  logic               spr0_hit,
    input  logic               spr_ovf,
    output logic [7:0]         oam_addr,
    output logic               oam_we,
    output logic [7:0]         oam_wdata,
    input  logic [7:0]         oam_rdata,
    output logic               vram_req,
    output logic               vram_we,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_wdata,
    input  logic               vram_ack,
    input  logic [7:0]         vram_rdata,
    output logic               drop
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]  state;
    logic        sel;
    logic        rd_acc;
    logic        wr_acc;
    logic [2:0]  r;
    logic [7:0]  d;
    logic [7:0]  rd_data;
    logic [7:0]  io_latch;
    logic [7:0]  read_buf;
    logic [14:0] v;
    logic [14:0] t;
    logic        w;
    logic        vblank;
    logic        busy;
    logic        acc7;
    logic        take7;
    logic        drop7;
    logic        status_rd;
    logic [14:0] v_inc;
    logic        unused_addr;

    assign sel    = (Addr_bus[15:13] == DEC_HI);
    assign r      = Addr_bus[2:0];
    assign d      = Data_bus_in;
    assign rd_acc = sel & R_nW;
    assign wr_acc = sel & ~R_nW;

    // Only the top three bits decode; the rest of the window mirrors.
    assign unused_addr = ^Addr_bus[12:3];

    assign busy      = (state == ST_BUSY);
    assign acc7      = sel & (r == 3'd7);
    // An ack in the same cycle frees the slot, so the new access is taken.
    assign take7     = acc7 & (~busy | vram_ack);
    assign drop7     = acc7 & busy & ~vram_ack;
    assign status_rd = rd_acc & (r == 3'd2);
    assign v_inc     = ctrl[2] ? 15'd32 : 15'd1;

    assign v_addr   = v;
    assign t_addr   = t;
    assign vram_req = busy;
    assign data_oe  = rd_acc;

    always_comb begin
        rd_data = io_latch;
        case (r)
            3'd2:    rd_data = {vblank, spr0_hit, spr_ovf, io_latch[4:0]};
            3'd4:    rd_data = oam_rdata;
            3'd7:    rd_data = read_buf;
            default: rd_data = io_latch;
        endcase
    end

    assign Data_bus_out = rd_acc ? rd_data : 8'h00;

    // CPU-visible control registers, open-bus latch and OAM port.
    always_ff @(posedge clk_ph2 or negedge rst) begin
        if (!rst) begin
            ctrl      <= 8'h00;
            mask      <= 8'h00;
            oam_addr  <= 8'h00;
            oam_we    <= 1'b0;
            oam_wdata <= 8'h00;
            io_latch  <= 8'h00;
        end else begin
            oam_we <= 1'b0;
            // Increment lands after the strobe so the write uses the old address.
            if (oam_we) begin
                oam_addr <= oam_addr + 8'd1;
            end
            if (wr_acc) begin
                io_latch <= d;
                case (r)
                    3'd0: ctrl <= d;
                    3'd1: mask <= d;
                    3'd3: oam_addr <= d;
                    3'd4: begin
                        oam_we    <= 1'b1;
                        oam_wdata <= d;
                    end
                    default: ;
                endcase
            end else if (rd_acc) begin
                io_latch <= rd_data;
            end
        end
    end

    // Scroll / address latches.
    always_ff @(posedge clk_ph2 or negedge rst) begin
        if (!rst) begin
            v      <= 15'h0000;
            t      <= 15'h0000;
            fine_x <= 3'd0;
            w      <= 1'b0;
        end else begin
            if (status_rd) begin
                w <= 1'b0;
            end
            if (wr_acc) begin
                case (r)
                    3'd0: t[11:10] <= d[1:0];
                    3'd5: begin
                        if (!w) begin
                            t[4:0] <= d[7:3];
                            fine_x <= d[2:0];
                            w      <= 1'b1;
                        end else begin
                            t[14:12] <= d[2:0];
                            t[9:5]   <= d[7:3];
                            w        <= 1'b0;
                        end
                    end
                    3'd6: begin
                        if (!w) begin
                            t[13:8] <= d[5:0];
                            t[14]   <= 1'b0;
                            w       <= 1'b1;
                        end else begin
                            t[7:0] <= d;
                            v      <= {t[14:8], d};
                            w      <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            if (take7) begin
                v <= v + v_inc;
            end
        end
    end

    // VRAM request FSM and PPUDATA read buffer.
    always_ff @(posedge clk_ph2 or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_wdata <= 8'h00;
            read_buf   <= 8'h00;
            drop       <= 1'b0;
        end else begin
            drop <= drop7;
            if (busy && vram_ack) begin
                state <= ST_IDLE;
                if (!vram_we) begin
                    read_buf <= vram_rdata;
                end
            end
            if (take7) begin
                state     <= ST_BUSY;
                vram_we   <= ~R_nW;
                vram_addr <= v[VRAM_AW-1:0];
                if (!R_nW) begin
                    vram_wdata <= d;
                end
            end
        end
    end

    // vblank flag and registered NMI output.
    always_ff @(posedge clk_ph2 or negedge rst) begin
        if (!rst) begin
            vblank <= 1'b0;
            nmi    <= 1'b1;
        end else begin
            nmi <= ~(vblank & ctrl[7]);
            // A status read racing vblank_set suppresses the flag.
            if (vblank_clr) begin
                vblank <= 1'b0;
            end else if (status_rd) begin
                vblank <= 1'b0;
            end else if (vblank_set) begin
                vblank <= 1'b1;
            end
        end
    end

endmodule

// File: doc/ppu_cpu_port.md
Name: ppu_cpu_port

Overview:
- CPU-facing register responder of the PPU: answers the CPU's bus cycles at $2000-$3FFF (8 registers, mirrored every 8 bytes).
- Holds PPUCTRL, PPUMASK, OAMADDR, the scroll/address latches (v, t, fine_x, write toggle w) and the PPUDATA read buffer.
- Forwards VRAM and OAM accesses to the PPU core through a request/acknowledge handshake.
- Drives the CPU's active-low nmi line.

Parameters:
- DEC_HI, 3'b001, value of Addr_bus[15:13] that selects this block.
- VRAM_AW, 14, width of the VRAM address to the PPU core.

Ports:
- clk_ph2  in  1  CPU cycle clock; one bus access per rising edge.
- rst  in  1  asynchronous, active-low reset.
- Addr_bus  in  16  CPU address.
- Data_bus_in  in  8  CPU write data.
- R_nW  in  1  1 = read, 0 = write.
- Data_bus_out  out  8  read data to the CPU.
- data_oe  out  1  high while a selected read is in progress.
- nmi  out  1  active-low NMI to the CPU.
- ctrl  out  8  PPUCTRL.
- mask  out  8  PPUMASK.
- v_addr  out  15  current VRAM address (v).
- t_addr  out  15  temporary address (t).
- fine_x  out  3  fine X scroll.
- vblank_set  in  1  pulse: start of vblank.
- vblank_clr  in  1  pulse: pre-render line.
- spr0_hit  in  1  sprite-0 hit flag from the core.
- spr_ovf  in  1  sprite overflow flag from the core.
- oam_addr  out  8  OAM address.
- oam_we  out  1  one-cycle OAM write strobe.
- oam_wdata  out  8  OAM write data.
- oam_rdata  in  8  OAM read data.
- vram_req  out  1  VRAM request, held until acknowledged.
- vram_we  out  1  1 = write request.
- vram_addr  out  VRAM_AW  VRAM request address.
- vram_wdata  out  8  VRAM write data.
- vram_ack  in  1  request complete; vram_rdata valid in this cycle.
- vram_rdata  in  8  VRAM read data.
- drop  out  1  one-cycle pulse: a $2007 access was ignored because a request was pending.

Behaviour:
- Select: sel = (Addr_bus[15:13] == DEC_HI); register index r = Addr_bus[2:0].
- Each clk_ph2 edge with sel high is exactly one access; its side effects are applied on that edge.
- Read data path:
  - Data_bus_out is combinational from Addr_bus and the current state, so it is valid before the edge on which the CPU latches it.
  - data_oe = sel & R_nW.
- Open bus: io_latch (8 bits) is loaded with Data_bus_in on every selected write and with Data_bus_out on every selected read.
- Reset (rst low, asynchronous):
  - ctrl, mask, oam_addr, v, t, fine_x, w, read_buf, io_latch, vblank = 0.
  - oam_we = 0, vram_req = 0, vram_we = 0, drop = 0.
  - nmi = 1.
  - A pending VRAM request is abandoned.
- Writes:
  - 0 (PPUCTRL): ctrl <= d; t[11:10] <= d[1:0].
  - 1 (PPUMASK): mask <= d.
  - 2 (PPUSTATUS): updates io_latch only.
  - 3 (OAMADDR): oam_addr <= d.
  - 4 (OAMDATA): oam_we pulses for one cycle with oam_wdata = d and the pre-increment address; then oam_addr += 1, wrapping $FF->$00.
  - 5 (PPUSCROLL), w=0: t[4:0] <= d[7:3]; fine_x <= d[2:0]; w <= 1.
  - 5 (PPUSCROLL), w=1: t[14:12] <= d[2:0]; t[9:5] <= d[7:3]; w <= 0.
  - 6 (PPUADDR), w=0: t[13:8] <= d[5:0]; t[14] <= 0; w <= 1.
  - 6 (PPUADDR), w=1: t[7:0] <= d; v <= new t; w <= 0.
  - 7 (PPUDATA): raise vram_req with vram_we = 1, vram_addr = v[13:0], vram_wdata = d; v += (ctrl[2] ? 32 : 1), modulo 2^15.
- Reads:
  - 2 (PPUSTATUS): returns {vblank, spr0_hit, spr_ovf, io_latch[4:0]}; side effects vblank <= 0, w <= 0.
  - 4 (OAMDATA): returns oam_rdata; no increment.
  - 7 (PPUDATA): returns read_buf; raises vram_req with vram_we = 0, vram_addr = v[13:0]; v increments as for writes; read_buf <= vram_rdata on vram_ack.
  - 0, 1, 3, 5, 6: return io_latch; no side effects.
- VRAM handshake FSM:
  - States IDLE and BUSY.
  - IDLE -> BUSY on a $2007 access; vram_req = 1 and the address, data and we fields are held stable in BUSY.
  - BUSY -> IDLE on vram_ack; vram_req drops on the following edge.
  - A $2007 access while BUSY is ignored: no v change, no buffer change, drop pulses. If that access is a read, it still returns the current read_buf.
  - An ack in the same cycle as a new $2007 access: the ack completes the old request, and the new access is taken and issued.
- vblank flag:
  - Set on vblank_set and cleared on vblank_clr; vblank_clr has priority.
  - A $2002 read in the same cycle as vblank_set returns bit 7 = 0, and the flag stays 0 (suppression).
- nmi = ~(vblank & ctrl[7]), registered:
  - It updates on the edge following the change.
  - Setting ctrl[7] while vblank = 1 pulls nmi low.
  - Clearing ctrl[7], reading $2002, or vblank_clr releases it.
- Non-selected cycles have no effect. R_nW and Addr_bus are sampled only at clk_ph2.

Test Plan:
- Reset, then read $2002 -> Data_bus_out = $00, nmi = 1, vram_req = 0, v = t = 0.
- Write $2006 = $21, then $2006 = $08 -> t = v = $2108. Then write $2007 = $5A with ctrl[2] = 0 -> vram_req with addr $2108, we = 1, wdata $5A; v = $2109. Ack after 3 cycles -> req drops.
- Set v = $2000. Read $2007 (returns reset buffer $00), ack with rdata $AB, read $2007 again -> second read returns $AB; v = $2002.
- Write $2005 = $7D, then $2005 = $5E -> fine_x = 5, t[4:0] = $0F, t[14:12] = 6, t[9:5] = $0B. Write $2005 = $7D, read $2002, write $2005 = $7D -> w reset, so the second write hits the first-write path again.
- Write $2000 = $80, pulse vblank_set -> nmi goes low next edge; read $2002 returns bit 7 = 1 and nmi returns high next edge. vblank_set coincident with a $2002 read -> bit 7 = 0 and vblank stays 0.
- Write $2003 = $FF, write $2004 = $11 -> oam_we with address $FF, then oam_addr = $00. Issue $2007 while BUSY -> drop pulses and v is unchanged.
